// File: rtl/md_cell_mem_pkg.sv
// Shared definitions for the per-cell velocity RAM readers: default widths,
// the reader state encoding and the address holding the particle count.
package md_cell_mem_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 96;
  localparam int unsigned DEF_ADDR_WIDTH = 8;
  localparam int unsigned COUNT_ADDR     = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_CNT,
    S_WAIT_CNT,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } rd_state_t;

endpackage

// File: rtl/vel_rd_fifo.sv
// Small synchronous FIFO holding {last, pid, data} entries returned from the
// velocity RAM until the consumer accepts them.
module vel_rd_fifo #(
  parameter int unsigned  DEPTH = 3,
  parameter int unsigned  WIDTH = 105,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             empty
);

  localparam int unsigned   PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && ((count != CW'(DEPTH)) || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/velocity_cell_reader.sv
// Read-side initiator for one cell velocity RAM: fetches the particle count,
// then streams every {vz,vy,vx} word out on a valid/ready interface.
module velocity_cell_reader
  import md_cell_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned PARTICLE_NUM = 220,
  parameter int unsigned RD_LATENCY   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  cell_done,
  output logic [ADDR_WIDTH-1:0] particle_cnt,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rden,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_pid,
  output logic                  out_last
);

  localparam int unsigned FIFO_DEPTH = RD_LATENCY + 2;
  localparam int unsigned EW         = DATA_WIDTH + ADDR_WIDTH + 1;
  localparam int unsigned CW         = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned LW         = $clog2(RD_LATENCY + 1) + 1;
  localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

  rd_state_t             state;
  rd_state_t             state_nx;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] cnt_clamped;
  logic [LW-1:0]         lat_cnt;
  logic                  latch_cnt;
  logic                  issue;
  logic                  credit;
  logic [CW:0]           inflight;
  logic                  trk_v   [RD_LATENCY];
  logic [ADDR_WIDTH-1:0] trk_pid [RD_LATENCY];
  logic [EW-1:0]         fifo_in;
  logic [EW-1:0]         fifo_q;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;

  assign cnt_clamped = (mem_q[ADDR_WIDTH-1:0] > MAX_CNT) ? MAX_CNT : mem_q[ADDR_WIDTH-1:0];

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RD_LATENCY; i++) begin
      inflight += (CW+1)'(trk_v[i]);
    end
  end

  assign credit = (inflight + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);

  always_comb begin
    state_nx  = state;
    mem_rden  = 1'b0;
    rd_addr   = next_addr;
    latch_cnt = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          mem_rden = 1'b1;
          rd_addr  = ADDR_WIDTH'(COUNT_ADDR);
          state_nx = S_RD_CNT;
        end
      end
      S_RD_CNT, S_WAIT_CNT: begin
        if (lat_cnt == LW'(RD_LATENCY)) begin
          latch_cnt = 1'b1;
          state_nx  = (cnt_clamped == '0) ? S_DONE : S_STREAM;
        end else begin
          state_nx = S_WAIT_CNT;
        end
      end
      S_STREAM: begin
        if (credit) begin
          mem_rden = 1'b1;
          if (next_addr == cnt_q) state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((inflight == '0) && fifo_empty) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign issue = (state == S_STREAM) && mem_rden;

  // The address bus parks on the last issued address between reads.
  assign mem_addr = mem_rden ? rd_addr : last_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      next_addr <= '0;
      last_addr <= '0;
      cnt_q     <= '0;
      lat_cnt   <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        trk_v[i]   <= 1'b0;
        trk_pid[i] <= '0;
      end
    end else begin
      state <= state_nx;
      if (mem_rden) last_addr <= rd_addr;
      if (state == S_IDLE) lat_cnt <= LW'(1);
      else if (state == S_RD_CNT || state == S_WAIT_CNT) lat_cnt <= lat_cnt + 1'b1;
      if (latch_cnt) begin
        cnt_q     <= cnt_clamped;
        next_addr <= ADDR_WIDTH'(1);
      end else if (issue) begin
        next_addr <= next_addr + 1'b1;
      end
      trk_v[0]   <= issue;
      trk_pid[0] <= next_addr - 1'b1;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        trk_v[i]   <= trk_v[i-1];
        trk_pid[i] <= trk_pid[i-1];
      end
    end
  end

  assign fifo_in = {(trk_pid[RD_LATENCY-1] == cnt_q - 1'b1), trk_pid[RD_LATENCY-1], mem_q};

  vel_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (trk_v[RD_LATENCY-1]),
    .push_data (fifo_in),
    .pop       (out_ready),
    .pop_data  (fifo_q),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign busy         = (state != S_IDLE);
  assign cell_done    = (state == S_DONE);
  assign particle_cnt = cnt_q;
  assign out_valid    = !fifo_empty;
  assign {out_last, out_pid, out_data} = fifo_empty ? '0 : fifo_q;

endmodule
